// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run controller for cpu3: drives its reset, watches halt/exception, times each run.
// Optional err_count output is enabled by defining CPU_RUN_CTRL_ERRCNT_EN.
module cpu_run_ctrl #(
   parameter int unsigned RST_CYCLES = 4,
   parameter int unsigned TIMEOUT_W  = 16,
   parameter int unsigned CYC_W      = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [TIMEOUT_W-1:0] timeout_limit,
   input  logic                 cpu_halt,
   input  logic                 cpu_exception,
   output logic                 cpu_rst_,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           status,
   output logic [CYC_W-1:0]     cycle_count
`ifdef CPU_RUN_CTRL_ERRCNT_EN
   ,
   output logic [7:0]           err_count
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RESET = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] STAT_NONE  = 2'b00;
   localparam logic [1:0] STAT_HALT  = 2'b01;
   localparam logic [1:0] STAT_EXC   = 2'b10;
   localparam logic [1:0] STAT_TMOUT = 2'b11;

   localparam logic [7:0]       RST_LAST = 8'(RST_CYCLES - 1);
   localparam logic [CYC_W-1:0] CYC_MAX  = '1;

   state_t               state_q, state_d;
   logic [7:0]           rst_cnt_q, rst_cnt_d;
   logic [TIMEOUT_W-1:0] limit_q, limit_d;
   logic [1:0]           status_q, status_d;
   logic [CYC_W-1:0]     cycle_q, cycle_d;
   logic                 cpu_rst_q, busy_q, done_q;

   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      limit_d   = limit_q;
      status_d  = status_q;
      cycle_d   = cycle_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_RESET;
               limit_d   = timeout_limit;
               status_d  = STAT_NONE;
               cycle_d   = '0;
               rst_cnt_d = '0;
            end
         end
         ST_RESET: begin
            if (rst_cnt_q == RST_LAST) begin
               state_d   = ST_RUN;
               rst_cnt_d = '0;
            end else begin
               rst_cnt_d = rst_cnt_q + 8'd1;
            end
         end
         ST_RUN: begin
            // Exception outranks halt, and halt outranks timeout on the limit cycle.
            if (cpu_exception) begin
               state_d  = ST_DONE;
               status_d = STAT_EXC;
            end else if (cpu_halt) begin
               state_d  = ST_DONE;
               status_d = STAT_HALT;
            end else if ((limit_q != '0) && (cycle_q == CYC_W'(limit_q))) begin
               state_d  = ST_DONE;
               status_d = STAT_TMOUT;
            end else if (cycle_q != CYC_MAX) begin
               cycle_d = cycle_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         rst_cnt_q <= '0;
         limit_q   <= '0;
         status_q  <= STAT_NONE;
         cycle_q   <= '0;
         cpu_rst_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
         limit_q   <= limit_d;
         status_q  <= status_d;
         cycle_q   <= cycle_d;
         cpu_rst_q <= (state_d == ST_RUN);
         busy_q    <= (state_d == ST_RESET) || (state_d == ST_RUN);
         done_q    <= (state_d == ST_DONE);
      end
   end

   assign cpu_rst_    = cpu_rst_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign status      = status_q;
   assign cycle_count = cycle_q;

`ifdef CPU_RUN_CTRL_ERRCNT_EN
   logic [7:0] err_q, err_d;

   always_comb begin
      err_d = err_q;
      if ((state_q == ST_DONE) && status_q[1] && (err_q != 8'hFF)) begin
         err_d = err_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_count = err_q;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed self-checking bench for cpu_run_ctrl.
module tb_cpu_run_ctrl;

   localparam int RST_CYCLES = 4;
   localparam int TIMEOUT_W  = 16;
   localparam int CYC_W      = 32;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic [TIMEOUT_W-1:0] timeout_limit = '0;
   logic                 cpu_halt = 1'b0;
   logic                 cpu_exception = 1'b0;
   logic                 cpu_rst_;
   logic                 busy;
   logic                 done;
   logic [1:0]           status;
   logic [CYC_W-1:0]     cycle_count;
`ifdef CPU_RUN_CTRL_ERRCNT_EN
   logic [7:0]           err_count;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   cpu_run_ctrl #(
      .RST_CYCLES (RST_CYCLES),
      .TIMEOUT_W  (TIMEOUT_W),
      .CYC_W      (CYC_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .timeout_limit (timeout_limit),
      .cpu_halt      (cpu_halt),
      .cpu_exception (cpu_exception),
      .cpu_rst_      (cpu_rst_),
      .busy          (busy),
      .done          (done),
      .status        (status),
      .cycle_count   (cycle_count)
`ifdef CPU_RUN_CTRL_ERRCNT_EN
      ,
      .err_count     (err_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete run. halt_at/exc_at are 1-based RUN cycle indices (0 = never).
   task automatic do_run(input int limit, input int halt_at, input int exc_at, input bit poke,
                         output bit finished, output int lat, output int pulses,
                         output logic [1:0] st, output logic [CYC_W-1:0] cnt,
                         output logic busy_dn, output logic rstn_dn);
      int k;
      timeout_limit = TIMEOUT_W'(limit);
      start = 1'b1;
      tick();
      start = poke;
      lat = 0;
      while (!cpu_rst_ && lat < 50) begin
         tick();
         lat++;
      end
      finished = 1'b0;
      pulses = 0;
      k = 1;
      while (k < 2000 && !finished) begin
         cpu_halt      = (k == halt_at);
         cpu_exception = (k == exc_at);
         tick();
         k++;
         if (done) finished = 1'b1;
      end
      cpu_halt = 1'b0;
      cpu_exception = 1'b0;
      st = status;
      cnt = cycle_count;
      busy_dn = busy;
      rstn_dn = cpu_rst_;
      if (finished) pulses = 1;
      tick();
      start = 1'b0;
      if (done) pulses++;
      tick();
      if (done) pulses++;
   endtask

   bit               fin;
   int               lat, pulses;
   logic [1:0]       st;
   logic [CYC_W-1:0] cnt;
   logic             bdn, rdn;

   initial begin
      #1;
      check("rst_cpu_rst_", cpu_rst_, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_status", status, 0);
      check("rst_count", cycle_count, 0);
      tick();
      rst = 1'b0;
      tick();

      // Normal halt on the 10th RUN cycle.
      do_run(100, 10, 0, 1'b0, fin, lat, pulses, st, cnt, bdn, rdn);
      check("halt_finished", fin, 1);
      check("halt_latency", lat, RST_CYCLES);
      check("halt_status", st, 2'b01);
      check("halt_count", cnt, 9);
      check("halt_pulses", pulses, 1);
      check("halt_busy_done", bdn, 0);
      check("halt_cpurst_done", rdn, 0);

      // Exception and halt together on the 3rd RUN cycle.
      do_run(100, 3, 3, 1'b0, fin, lat, pulses, st, cnt, bdn, rdn);
      check("exc_status", st, 2'b10);
      check("exc_count", cnt, 2);

      // Timeout with no halt.
      do_run(20, 0, 0, 1'b0, fin, lat, pulses, st, cnt, bdn, rdn);
      check("tmo_status", st, 2'b11);
      check("tmo_count", cnt, 20);
      check("tmo_pulses", pulses, 1);

      // Halt on the limit cycle wins over timeout.
      do_run(20, 21, 0, 1'b0, fin, lat, pulses, st, cnt, bdn, rdn);
      check("lim_halt_status", st, 2'b01);
      check("lim_halt_count", cnt, 20);

      // No timeout, long run.
      do_run(0, 301, 0, 1'b0, fin, lat, pulses, st, cnt, bdn, rdn);
      check("nolim_status", st, 2'b01);
      check("nolim_count", cnt, 300);

      // start held through RESET/RUN/DONE must not disturb or requeue.
      do_run(100, 5, 0, 1'b1, fin, lat, pulses, st, cnt, bdn, rdn);
      check("poke_latency", lat, RST_CYCLES);
      check("poke_status", st, 2'b01);
      check("poke_count", cnt, 4);
      check("poke_pulses", pulses, 1);
      for (int i = 0; i < 3; i++) tick();
      check("poke_idle_busy", busy, 0);
      check("hold_status", status, 2'b01);
      check("hold_count", cycle_count, 4);

      // Asynchronous reset in the middle of a run.
      timeout_limit = 16'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < RST_CYCLES + 6; i++) tick();
      check("mid_busy_pre", busy, 1);
      check("mid_cpurst_pre", cpu_rst_, 1);
      rst = 1'b1;
      #1;
      check("mid_cpu_rst_", cpu_rst_, 0);
      check("mid_busy", busy, 0);
      check("mid_status", status, 0);
      check("mid_count", cycle_count, 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("post_rst_busy", busy, 0);
      check("post_rst_cpurst", cpu_rst_, 0);

`ifdef CPU_RUN_CTRL_ERRCNT_EN
      check("err_after_rst", err_count, 0);
      do_run(100, 0, 4, 1'b0, fin, lat, pulses, st, cnt, bdn, rdn);
      do_run(10, 0, 0, 1'b0, fin, lat, pulses, st, cnt, bdn, rdn);
      do_run(100, 4, 0, 1'b0, fin, lat, pulses, st, cnt, bdn, rdn);
      do_run(100, 0, 2, 1'b0, fin, lat, pulses, st, cnt, bdn, rdn);
      check("err_count_3", err_count, 3);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("err_keep_start", err_count, 3);
      rst = 1'b1;
      #1;
      check("err_cleared", err_count, 0);
      tick();
      rst = 1'b0;
      tick();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
